event_encoder_4to2: RTL and testbench

//  Converse of the 2-to-4 decoder: captures rising-edge events on 4 request lines and encodes each as a 2-bit code.

---
 rtl/event_encoder_4to2.sv | 194 +++++++++++++++++++
 tb/tb_event_encoder_4to2.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/event_encoder_4to2.sv
// event_encoder_4to2
// Captures rising edges on four request lines and encodes each one as a
// 2-bit code. The mapping is the inverse of a 2-to-4 decoder: ip[3]->00,
// ip[2]->01, ip[1]->10, ip[0]->11. Captured events wait in a pending
// register. At most one pending event per cycle is pushed, highest line
// first, into a small code FIFO. The FIFO drains through a valid/ready port.
//
// Optional feature: define ENC_OVF_COUNT_EN to add the ovf_cnt[7:0] output.
// This is a saturating count of lost events. Without the macro, only the
// sticky ovf flag is present.

module event_encoder_4to2 #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] ip,
   input  logic       Enable,
   output logic [1:0] op,
   output logic       valid,
   input  logic       ready,
   output logic       ovf,
   input  logic       clr_ovf
`ifdef ENC_OVF_COUNT_EN
   ,
   output logic [7:0] ovf_cnt
`endif
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic [3:0]    r_ipD;
   logic [3:0]    r_pend;
   logic [1:0]    r_mem [FIFO_DEPTH];
   logic [PW-1:0] r_wrPtr;
   logic [PW-1:0] r_rdPtr;
   logic [CW-1:0] r_count;
   logic [1:0]    r_op;
   logic          r_valid;
   logic          r_ovf;

   logic [3:0]    w_ev;
   logic [3:0]    w_sel;
   logic [1:0]    w_pushCode;
   logic          w_pop;
   logic          w_push;
   logic [3:0]    w_served;
   logic [3:0]    w_lost;
   logic          w_anyLost;
   logic [CW-1:0] w_countAfterPop;
   logic [CW-1:0] w_nextCount;
   logic [PW-1:0] w_nextRdPtr;
   logic [1:0]    w_nextHead;

   // An event is a 0->1 step seen while capture is enabled. A line that is
   // already high when Enable drops therefore produces nothing.
   assign w_ev = ip & ~r_ipD & {4{~Enable}};

   // Pick the highest-priority pending bit and the code it maps to.
   always_comb begin
      w_sel      = 4'b0000;
      w_pushCode = 2'b00;
      if (r_pend[3]) begin
         w_sel      = 4'b1000;
         w_pushCode = 2'b00;
      end else if (r_pend[2]) begin
         w_sel      = 4'b0100;
         w_pushCode = 2'b01;
      end else if (r_pend[1]) begin
         w_sel      = 4'b0010;
         w_pushCode = 2'b10;
      end else if (r_pend[0]) begin
         w_sel      = 4'b0001;
         w_pushCode = 2'b11;
      end
   end

   // Free space counts the slot released by this cycle's pop. A full FIFO
   // that is popping can therefore still accept a push.
   assign w_pop           = r_valid & ready;
   assign w_countAfterPop = r_count - CW'(w_pop);
   assign w_push          = (r_pend != 4'b0000) && (w_countAfterPop < CW'(FIFO_DEPTH));
   assign w_served        = w_push ? w_sel : 4'b0000;
   assign w_nextCount     = w_countAfterPop + CW'(w_push);
   assign w_nextRdPtr     = w_pop ? (r_rdPtr + PW'(1)) : r_rdPtr;

   // An event is lost only if its line already holds an unserved event.
   // If the bit is drained in the same cycle, the new event takes its place.
   assign w_lost    = w_ev & r_pend & ~w_served;
   assign w_anyLost = |w_lost;

   // The head slot is being written only when the FIFO is empty after the
   // pop. In that case the new code bypasses the memory into the head.
   assign w_nextHead = (w_push && (r_wrPtr == w_nextRdPtr)) ? w_pushCode
                                                            : r_mem[w_nextRdPtr];

   // Remember last cycle's request levels for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ipD <= 4'b0000;
      end else begin
         r_ipD <= ip;
      end
   end

   // Each line holds at most one pending event until it is pushed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend <= 4'b0000;
      end else begin
         r_pend <= (r_pend & ~w_served) | w_ev;
      end
   end

   // Code storage, written at the tail on each push.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= 2'b00;
         end
      end else if (w_push) begin
         r_mem[r_wrPtr] <= w_pushCode;
      end
   end

   // Wrapping read/write pointers and the occupancy count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + PW'(1);
         end
         r_rdPtr <= w_nextRdPtr;
         r_count <= w_nextCount;
      end
   end

   // Registered head of the FIFO. op keeps its last code once the FIFO
   // drains, so the consumer never sees a stale memory slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op    <= 2'b00;
         r_valid <= 1'b0;
      end else begin
         r_valid <= (w_nextCount != '0);
         if (w_nextCount != '0) begin
            r_op <= w_nextHead;
         end
      end
   end

   // Sticky loss flag. A loss in the same cycle as a clear keeps it set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (w_anyLost) begin
         r_ovf <= 1'b1;
      end else if (clr_ovf) begin
         r_ovf <= 1'b0;
      end
   end

`ifdef ENC_OVF_COUNT_EN
   logic [7:0] r_ovfCnt;
   logic [2:0] w_lostNum;
   logic [8:0] w_cntSum;

   assign w_lostNum = 3'(w_lost[0]) + 3'(w_lost[1]) + 3'(w_lost[2]) + 3'(w_lost[3]);
   assign w_cntSum  = {1'b0, r_ovfCnt} + 9'(w_lostNum);

   // Saturating count of lost events. An increment takes precedence over
   // a clear in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovfCnt <= 8'h00;
      end else if (w_anyLost) begin
         r_ovfCnt <= w_cntSum[8] ? 8'hFF : w_cntSum[7:0];
      end else if (clr_ovf) begin
         r_ovfCnt <= 8'h00;
      end
   end

   assign ovf_cnt = r_ovfCnt;
`endif

   assign op    = r_op;
   assign valid = r_valid;
   assign ovf   = r_ovf;

endmodule

// File: tb/tb_event_encoder_4to2.sv
// Testbench for event_encoder_4to2.
// The reference model keeps a queue of codes and a set of pending lines.
// Outputs are compared against it on every falling clock edge. Directed
// scenarios add constant expectations at their key points.
// Define ENC_OVF_COUNT_EN to also check ovf_cnt.

module tb_event_encoder_4to2;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] ip;
   logic       Enable;
   logic [1:0] op;
   logic       valid;
   logic       ready;
   logic       ovf;
   logic       clr_ovf;
`ifdef ENC_OVF_COUNT_EN
   logic [7:0] ovf_cnt;
`endif

   int vectors    = 0;
   int miscompares = 0;

   int       mQ[$];
   bit [3:0] mPend;
   bit [3:0] mIpPrev;
   bit       mOvf;
   int       mCnt;
   bit [1:0] mOp;

   event_encoder_4to2 #(.FIFO_DEPTH(DEPTH)) dut (
      .clk     (clk),
      .rst     (rst),
      .ip      (ip),
      .Enable  (Enable),
      .op      (op),
      .valid   (valid),
      .ready   (ready),
      .ovf     (ovf),
      .clr_ovf (clr_ovf)
`ifdef ENC_OVF_COUNT_EN
      ,
      .ovf_cnt (ovf_cnt)
`endif
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      mQ.delete();
      mPend   = 4'b0000;
      mIpPrev = 4'b0000;
      mOvf    = 1'b0;
      mCnt    = 0;
      mOp     = 2'b00;
   endtask

   // One clock edge of the behaviour, written from the rules of the design.
   task automatic modelStep(input logic [3:0] ipV, input logic enV, input logic rdyV, input logic clrV);
      bit [3:0] ev;
      int servedK = -1;
      int lostN = 0;
      for (int k = 0; k < 4; k++) begin
         ev[k] = ipV[k] && !mIpPrev[k] && !enV;
      end
      if (mQ.size() > 0 && rdyV) begin
         void'(mQ.pop_front());
      end
      if (mPend != 0 && mQ.size() < DEPTH) begin
         for (int k = 3; k >= 0; k--) begin
            if (mPend[k] && servedK < 0) begin
               servedK = k;
            end
         end
         mQ.push_back(3 - servedK);
      end
      for (int k = 0; k < 4; k++) begin
         if (ev[k] && mPend[k] && k != servedK) begin
            lostN++;
         end
      end
      if (servedK >= 0) begin
         mPend[servedK] = 1'b0;
      end
      mPend = mPend | ev;
      if (lostN > 0) begin
         mOvf = 1'b1;
         mCnt = (mCnt + lostN > 255) ? 255 : mCnt + lostN;
      end else if (clrV) begin
         mOvf = 1'b0;
         mCnt = 0;
      end
      if (mQ.size() > 0) begin
         mOp = 2'(mQ[0]);
      end
      mIpPrev = ipV;
   endtask

   task automatic checkOutput();
      checkVal("valid", 9'(valid), 9'(mQ.size() != 0));
      checkVal("op", 9'(op), 9'(mOp));
      checkVal("ovf", 9'(ovf), 9'(mOvf));
`ifdef ENC_OVF_COUNT_EN
      checkVal("ovf_cnt", 9'(ovf_cnt), 9'(mCnt));
`endif
   endtask

   // Called at a falling edge: check the state left by the last rising
   // edge, drive the next inputs, advance the model, then wait one cycle.
   task automatic applyStimulus(input logic [3:0] ipV, input logic enV, input logic rdyV, input logic clrV);
      checkOutput();
      ip      = ipV;
      Enable  = enV;
      ready   = rdyV;
      clr_ovf = clrV;
      modelStep(ipV, enV, rdyV, clrV);
      @(negedge clk);
   endtask

   // Assert reset away from any clock edge and check that it acts at once.
   task automatic doReset();
      #2 rst = 1'b1;
      #1;
      checkVal("rst_valid", 9'(valid), 9'd0);
      checkVal("rst_op", 9'(op), 9'd0);
      checkVal("rst_ovf", 9'(ovf), 9'd0);
`ifdef ENC_OVF_COUNT_EN
      checkVal("rst_cnt", 9'(ovf_cnt), 9'd0);
`endif
      modelReset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int drain[6];
      rst = 1'b1;
      ip = 4'b0000;
      Enable = 1'b0;
      ready = 1'b0;
      clr_ovf = 1'b0;
      modelReset();
      @(negedge clk);
      @(negedge clk);
      checkVal("init_valid", 9'(valid), 9'd0);
      checkVal("init_op", 9'(op), 9'd0);
      checkVal("init_ovf", 9'(ovf), 9'd0);
      rst = 1'b0;

      $display("[TB] single event");
      applyStimulus(4'b0001, 1'b0, 1'b1, 1'b0);
      applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0);
      checkVal("single_valid", 9'(valid), 9'd1);
      checkVal("single_op", 9'(op), 9'd3);
      applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0);
      checkVal("single_pop", 9'(valid), 9'd0);

      $display("[TB] priority");
      applyStimulus(4'b1111, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0);
         checkVal("prio_op", 9'(op), 9'(i));
         checkVal("prio_valid", 9'(valid), 9'd1);
      end
      applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0);
      checkVal("prio_ovf", 9'(ovf), 9'd0);

      $display("[TB] backpressure");
      applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
      checkVal("bp_valid", 9'(valid), 9'd1);
      checkVal("bp_op", 9'(op), 9'd0);
      checkVal("bp_noovf", 9'(ovf), 9'd0);
      applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
      checkVal("bp_ovf", 9'(ovf), 9'd1);
      checkVal("bp_hold_op", 9'(op), 9'd0);
`ifdef ENC_OVF_COUNT_EN
      checkVal("bp_cnt", 9'(ovf_cnt), 9'd1);
`endif
      drain = '{0, 1, 2, 3, 0, 1};
      checkVal("drain_op", 9'(op), 9'(drain[0]));
      for (int i = 1; i < 6; i++) begin
         applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0);
         checkVal("drain_op", 9'(op), 9'(drain[i]));
      end
      applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0);
      checkVal("drain_empty", 9'(valid), 9'd0);
      checkVal("drain_keep_op", 9'(op), 9'd1);

      $display("[TB] enable gating");
      applyStimulus(4'b0100, 1'b1, 1'b1, 1'b0);
      applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0);
      applyStimulus(4'b0100, 1'b1, 1'b1, 1'b0);
      applyStimulus(4'b0100, 1'b0, 1'b1, 1'b0);
      applyStimulus(4'b0100, 1'b0, 1'b1, 1'b0);
      applyStimulus(4'b0100, 1'b0, 1'b1, 1'b0);
      checkVal("en_nocode", 9'(valid), 9'd0);
      applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0);
      applyStimulus(4'b0100, 1'b0, 1'b1, 1'b0);
      applyStimulus(4'b0100, 1'b0, 1'b1, 1'b0);
      checkVal("en_code_valid", 9'(valid), 9'd1);
      checkVal("en_code_op", 9'(op), 9'd1);
      applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0);
      checkVal("en_single", 9'(valid), 9'd0);

      $display("[TB] overflow clear");
      applyStimulus(4'b0000, 1'b0, 1'b1, 1'b1);
      checkVal("clr_ovf", 9'(ovf), 9'd0);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0);
         applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
      end
      checkVal("fill_ovf", 9'(ovf), 9'd1);
      applyStimulus(4'b1111, 1'b0, 1'b0, 1'b1);
      checkVal("clr_vs_loss", 9'(ovf), 9'd1);
      applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
      checkVal("clr_quiet", 9'(ovf), 9'd0);
`ifdef ENC_OVF_COUNT_EN
      checkVal("clr_cnt", 9'(ovf_cnt), 9'd0);
`endif
      for (int i = 0; i < 80; i++) begin
         applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0);
         applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
      end
      checkVal("many_ovf", 9'(ovf), 9'd1);
`ifdef ENC_OVF_COUNT_EN
      checkVal("cnt_sat", 9'(ovf_cnt), 9'd255);
`endif

      $display("[TB] reset mid-stream");
      doReset();
      applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
      checkVal("post_rst_valid", 9'(valid), 9'd0);

      $display("[TB] random traffic");
      for (int i = 0; i < 600; i++) begin
         if (i == 300) begin
            doReset();
         end
         applyStimulus(4'($urandom_range(0, 15)),
                       $urandom_range(0, 3) == 0,
                       $urandom_range(0, 2) != 0,
                       $urandom_range(0, 15) == 0);
      end
      checkOutput();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
